// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - in-order reservation-station queue with CDB snooping and ID pool
// Optional flush port enabled by defining RS_QUEUE_FLUSH_EN.
module rs_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 2,
  parameter int ID_BASE = 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nRST,
`ifdef RS_QUEUE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [OP_W-1:0]   enq_op,
  input  logic [DATA_W-1:0] enq_a_data,
  input  logic [DATA_W-1:0] enq_b_data,
  input  logic [TAG_W-1:0]  enq_a_tag,
  input  logic [TAG_W-1:0]  enq_b_tag,
  output logic [TAG_W-1:0]  enq_id,
  input  logic              bc_valid,
  input  logic [TAG_W-1:0]  bc_tag,
  input  logic [DATA_W-1:0] bc_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OP_W-1:0]   iss_op,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [TAG_W-1:0]  iss_id,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [OP_W-1:0]   e_op [DEPTH];
  logic [TAG_W-1:0]  e_at [DEPTH];
  logic [TAG_W-1:0]  e_bt [DEPTH];
  logic [TAG_W-1:0]  e_id [DEPTH];
  logic [DATA_W-1:0] e_ad [DEPTH];
  logic [DATA_W-1:0] e_bd [DEPTH];
  logic [DEPTH-1:0]  id_free;
  logic [CW-1:0]     cnt;

  logic              flush_w, bc_hit, pop, push;
  logic [CW-1:0]     wr_idx;
  logic [TAG_W-1:0]  free_id;
  logic [TAG_W-1:0]  n_at, n_bt;
  logic [DATA_W-1:0] n_ad, n_bd;
  logic [TAG_W-1:0]  s_at [DEPTH];
  logic [TAG_W-1:0]  s_bt [DEPTH];
  logic [DATA_W-1:0] s_ad [DEPTH];
  logic [DATA_W-1:0] s_bd [DEPTH];
  logic [OP_W-1:0]   x_op [DEPTH];
  logic [TAG_W-1:0]  x_at [DEPTH];
  logic [TAG_W-1:0]  x_bt [DEPTH];
  logic [TAG_W-1:0]  x_id [DEPTH];
  logic [DATA_W-1:0] x_ad [DEPTH];
  logic [DATA_W-1:0] x_bd [DEPTH];

`ifdef RS_QUEUE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  function automatic int nxt(input int i);
    return (i < DEPTH - 1) ? i + 1 : i;
  endfunction

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign count     = cnt;
  // iss_valid looks only at stored tags so a broadcast cannot raise it combinationally
  assign iss_valid = !empty && (e_at[0] == '0) && (e_bt[0] == '0) && !flush_w;
  assign pop       = iss_valid && iss_ready;
  assign enq_ready = (!full || pop) && !flush_w;
  assign push      = enq_valid && enq_ready;
  assign wr_idx    = cnt - CW'(pop);
  assign bc_hit    = bc_valid && (bc_tag != '0);

  assign iss_op = empty ? '0 : e_op[0];
  assign iss_a  = empty ? '0 : e_ad[0];
  assign iss_b  = empty ? '0 : e_bd[0];
  assign iss_id = empty ? '0 : e_id[0];

  assign n_at = (bc_hit && enq_a_tag == bc_tag) ? '0 : enq_a_tag;
  assign n_ad = (bc_hit && enq_a_tag == bc_tag) ? bc_data : enq_a_data;
  assign n_bt = (bc_hit && enq_b_tag == bc_tag) ? '0 : enq_b_tag;
  assign n_bd = (bc_hit && enq_b_tag == bc_tag) ? bc_data : enq_b_data;

  // Snoop every stored operand, then select the shifted or held view
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      s_at[i] = (bc_hit && e_at[i] == bc_tag) ? '0 : e_at[i];
      s_ad[i] = (bc_hit && e_at[i] == bc_tag) ? bc_data : e_ad[i];
      s_bt[i] = (bc_hit && e_bt[i] == bc_tag) ? '0 : e_bt[i];
      s_bd[i] = (bc_hit && e_bt[i] == bc_tag) ? bc_data : e_bd[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      x_op[i] = pop ? e_op[nxt(i)] : e_op[i];
      x_at[i] = pop ? s_at[nxt(i)] : s_at[i];
      x_ad[i] = pop ? s_ad[nxt(i)] : s_ad[i];
      x_bt[i] = pop ? s_bt[nxt(i)] : s_bt[i];
      x_bd[i] = pop ? s_bd[nxt(i)] : s_bd[i];
      x_id[i] = pop ? e_id[nxt(i)] : e_id[i];
    end
  end

  always_comb begin
    free_id = TAG_W'(ID_BASE);
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (id_free[j]) free_id = TAG_W'(ID_BASE + j);
    end
  end

  assign enq_id = (full && pop) ? e_id[0] : free_id;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_op[i] <= '0; e_at[i] <= '0; e_bt[i] <= '0;
        e_ad[i] <= '0; e_bd[i] <= '0; e_id[i] <= '0;
      end
      id_free <= '1;
      cnt     <= '0;
    end else if (flush_w) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_op[i] <= '0; e_at[i] <= '0; e_bt[i] <= '0;
        e_ad[i] <= '0; e_bd[i] <= '0; e_id[i] <= '0;
      end
      id_free <= '1;
      cnt     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_idx == CW'(i)) begin
          e_op[i] <= enq_op; e_at[i] <= n_at; e_ad[i] <= n_ad;
          e_bt[i] <= n_bt;   e_bd[i] <= n_bd; e_id[i] <= enq_id;
        end else begin
          e_op[i] <= x_op[i]; e_at[i] <= x_at[i]; e_ad[i] <= x_ad[i];
          e_bt[i] <= x_bt[i]; e_bd[i] <= x_bd[i]; e_id[i] <= x_id[i];
        end
      end
      // A claim wins over a release so a full-queue reuse keeps its ID allocated
      for (int j = 0; j < DEPTH; j++) begin
        if (push && enq_id == TAG_W'(ID_BASE + j))
          id_free[j] <= 1'b0;
        else if (pop && e_id[0] == TAG_W'(ID_BASE + j))
          id_free[j] <= 1'b1;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- Parametrised in-order reservation-station queue for the Tomasulo datapath, the successor to the single-operand 3-entry queue.
- Holds up to DEPTH instructions, each with two source operands (A, B) and an op code, and snoops the common data bus (CDB) to resolve operand tags.
- Issues the head entry to its functional unit over a valid/ready handshake.
- Assigns each entry a unique reservation-station ID that producers later broadcast on.

Parameters:
- DEPTH, 4: number of entries, at least 2.
- DATA_W, 32: operand width.
- TAG_W, 4: tag/ID width. Tag value 0 means "operand ready".
- OP_W, 2: op-code width.
- ID_BASE, 1: first RS ID. Constraints: ID_BASE >= 1 and ID_BASE+DEPTH-1 < 2^TAG_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- enq_valid  in  1  enqueue request.
- enq_ready  out  1  enqueue accepted this cycle.
- enq_op  in  OP_W  op code.
- enq_a_data / enq_b_data  in  DATA_W  operand values (meaningful when the matching tag is 0).
- enq_a_tag / enq_b_tag  in  TAG_W  producer tags.
- enq_id  out  TAG_W  ID assigned to the entry being enqueued.
- bc_valid  in  1  CDB broadcast valid.
- bc_tag  in  TAG_W  CDB tag.
- bc_data  in  DATA_W  CDB value.
- iss_valid  out  1  head entry present with both tags 0.
- iss_ready  in  1  functional unit can accept.
- iss_op  out  OP_W  head op code.
- iss_a / iss_b  out  DATA_W  head operand values.
- iss_id  out  TAG_W  head entry ID.
- count  out  $clog2(DEPTH+1)  occupied entries.
- full / empty  out  1  count==DEPTH / count==0.

Behaviour:
- Reset (asynchronous, nRST low, any time including mid-operation):
  - all entries invalid, all tags/data/op/ID cleared, ID pool all free.
  - count=0, empty=1, full=0, iss_valid=0, iss_* = 0, enq_id = ID_BASE.
- Storage: entries 0..count-1, entry 0 is the head. Strict in-order issue; no bypass around the head.
- iss_* are driven combinationally from entry 0. When empty, iss_* = 0 and iss_valid = 0.
- pop = iss_valid && iss_ready.
  - On the edge, entries shift down by one, so there is single-cycle compaction.
  - The popped ID returns to the pool.
- enq_ready = !full || pop.
- push = enq_valid && enq_ready.
  - The new entry is written at index count - pop.
  - An enqueue with enq_ready=0 is ignored; no state changes.
- enq_id (combinational):
  - if full && pop: the popped head's ID is reused.
  - otherwise: ID_BASE + the lowest free pool index.
- Broadcast (bc_valid && bc_tag != 0):
  - Every stored operand whose tag == bc_tag captures bc_data and its tag becomes 0. This includes entries moving during a shift.
  - An incoming enq operand whose tag == bc_tag is stored with bc_data and tag 0 in the same cycle.
  - A broadcast with bc_tag == 0 is ignored.
- Broadcast-to-issue latency: a broadcast resolves the head's last operand at edge N; iss_valid rises after edge N. A broadcast never combinationally raises iss_valid in the same cycle.
- Simultaneous push + pop: count is unchanged, and full stays asserted if it was asserted.
- Simultaneous push + pop + broadcast: all three are applied in the same edge.
- count, full and empty are registered-state derived. They update on the edge following push/pop.

Optional Feature:
- Macro: RS_QUEUE_FLUSH_EN.
- When defined:
  - Adds input flush (1 bit).
  - flush=1 at an edge invalidates all entries and frees all IDs, with the same end state as reset.
  - flush has priority over push, pop and broadcast in that cycle.
  - enq_ready is forced to 0 and iss_valid to 0 while flush=1.
- When undefined: no flush port; entries leave only via issue or reset.

Test Plan:
- Reset then enqueue ops A=5/tag0, B=7/tag0 with iss_ready=1 -> iss_valid=1 the next cycle, iss_a=5, iss_b=7, iss_id=1; popped the following edge, count back to 0.
- Enqueue with A tag=3, B ready; hold iss_ready=1; broadcast tag3 data 0xABCD two cycles later -> iss_valid=0 until the cycle after the broadcast, then iss_a=0xABCD.
- Enqueue with A tag=2 in the same cycle as broadcast tag2 data 9 -> entry stored ready; iss_valid=1 the next cycle with iss_a=9.
- Fill 4 entries (IDs 1,2,3,4), full=1; head ready, iss_ready=1, enq_valid=1 -> enq_ready=1, enq_id=1 reused, count stays 4, new entry at tail.
- Head blocked on tag 5, entry 1 ready -> no issue (in-order); broadcast tag5 -> head issues, then entry 1 issues on the next cycle.
- Assert nRST low mid-stream with 3 entries -> count=0, iss_valid=0 immediately; next enqueue gets enq_id=1. With RS_QUEUE_FLUSH_EN, flush=1 gives the identical result at the edge.
